macc_psum_requant: RTL and testbench
====================================

# macc_psum_requant

Consumer-side companion to the 8-bit MACC/adder-tree datapath. It takes the stream of signed partial sums produced by `macc_8bit_single` (one sum per group of NUM_INPUTS products) and accumulates NUM_CHUNKS consecutive sums plus a bias into one output neuron. The result is requantized by a rounding arithmetic right shift and clamped to an unsigned 8-bit activation, the format the MACC consumes on its activation operand. This closes the loop between layers.

## Interface
- NUM_INPUTS, 20: products per MACC sum; sets IN_WIDTH = 17 + $clog2(NUM_INPUTS) (localparam, 22 at default)
- NUM_CHUNKS, 4: MACC sums per output neuron, >= 1
- ACC_WIDTH, 32: accumulator/bias width, >= IN_WIDTH + 1
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_data  in  IN_WIDTH  signed partial sum from MACC adder tree
- i_valid  in  1  i_data valid this cycle
- i_bias  in  ACC_WIDTH  signed bias, sampled on chunk-0 beats
- i_shift  in  5  requant right-shift amount, 0..31, sampled on last-chunk beats
- i_clear  in  1  synchronous abort/clear
- o_data  out  8  unsigned requantized activation
- o_valid  out  1  o_data valid, one-cycle pulse per neuron
- o_busy  out  1  neuron partially accumulated (chunk counter != 0)
- o_ovf  out  1  sticky accumulator signed-overflow flag

## Operation
- Chunk counter cnt: 0..NUM_CHUNKS-1. It increments on each accepted i_valid and wraps to 0 after NUM_CHUNKS-1. With NUM_CHUNKS=1, every beat is both first and last.
- Stage 1, accumulate, on accepted beat:
  - cnt==0: acc <= i_bias + sext(i_data).
  - otherwise: acc <= acc + sext(i_data).
  - Arithmetic wraps modulo 2^ACC_WIDTH (two's complement).
  - Signed overflow on either add sets o_ovf; it stays set until i_clear or reset.
- Last beat (cnt==NUM_CHUNKS-1) also latches i_shift and sets the stage-1 "done" flag.
- Stage 2, round/shift: r = (acc + rnd) >>> shift, where rnd = 1<<(shift-1) if shift>0, else 0. Computed in ACC_WIDTH+1 bits so the rounding add cannot overflow.
- Stage 3, clamp: r<0 gives 0; r>255 gives 255; otherwise r[7:0]. ReLU is inherent. o_valid pulses.
- Pipelined with no backpressure. A chunk-0 beat of the next neuron may arrive on the cycle immediately after a last beat; stage 1 then restarts from bias while stages 2/3 finish the previous neuron.
- i_clear (sync, highest priority):
  - Forces cnt=0 and acc=0, clears o_ovf, and kills the done flags in stages 2/3, so no o_valid appears for in-flight neurons.
  - An i_valid in the same cycle is dropped.
  - The cycle after, the block is equivalent to post-reset.
- i_valid low: no state change; stage 2/3 results still drain.
- o_busy = (cnt != 0), registered with the counter.

## Timing
- Reset values: o_data=0, o_valid=0, o_busy=0, o_ovf=0, cnt=0, acc=0, all stage flags 0.
- Latency: the last-chunk beat is accepted on edge T. o_valid=1 and o_data are valid in the cycle following edge T+2 (2 cycles after acceptance).
- Throughput: one i_valid per cycle sustained. One o_valid per NUM_CHUNKS accepted beats.
- o_data holds its last value while o_valid=0.
- o_ovf updates the cycle after the overflowing beat.
- A reset asserted mid-neuron discards everything asynchronously. The first beat after release is chunk 0.

## Test plan
- Basic: NUM_CHUNKS=4, bias=0, shift=8, chunks 100,200,300,424 (sum 1024) -> o_data=4, o_valid for exactly 1 cycle, 2 cycles after the 4th beat; o_busy high after beats 1-3, low after beat 4.
- Rounding/clamp, with shift=8: sum 383 -> 1; sum 384 -> 2; sum -5000 -> 0; sum 100000 -> 255. With shift=0: sum 7 -> 7.
- Bias: bias=-256, chunks 512,0,0,0, shift=8 -> 1. Bias change on a non-chunk-0 beat has no effect.
- Back-to-back: 8 consecutive i_valid beats (two neurons, sums 1024 and 2048, shift 8) -> o_valid pulses exactly 4 cycles apart with values 4 then 8.
- Clear/gaps: i_valid gaps between chunks give the same result as gap-free input. i_clear after 2 beats, then 4 fresh beats -> only the fresh neuron's output. i_clear one cycle after a last beat -> no o_valid for that neuron.
- Overflow: bias=0x7FFFFFF0, chunks 0x100,0,0,0 -> o_ovf=1 and stays set across later neurons until i_clear. Reset mid-neuron -> all outputs 0, next beat treated as chunk 0.

Source files
------------

// File: rtl/macc_psum_requant.sv
// Accumulates NUM_CHUNKS signed MACC partial sums plus a bias into one neuron, then
// requantizes with a rounding arithmetic right shift and clamps to an unsigned 8-bit activation.
module macc_psum_requant #(
   parameter int NUM_INPUTS = 20,
   parameter int NUM_CHUNKS = 4,
   parameter int ACC_WIDTH  = 32,
   localparam int IN_WIDTH  = 17 + $clog2(NUM_INPUTS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [IN_WIDTH-1:0]  i_data,
   input  logic                        i_valid,
   input  logic signed [ACC_WIDTH-1:0] i_bias,
   input  logic [4:0]                  i_shift,
   input  logic                        i_clear,
   output logic [7:0]                  o_data,
   output logic                        o_valid,
   output logic                        o_busy,
   output logic                        o_ovf
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   logic [CNT_W-1:0]            cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] data_ext;
   logic signed [ACC_WIDTH-1:0] add_a;
   logic signed [ACC_WIDTH-1:0] add_sum;
   logic                        add_ovf;
   logic                        first_beat;
   logic                        last_beat;
   logic                        done1;
   logic [4:0]                  shift1;

   logic signed [ACC_WIDTH:0]   rnd;
   logic signed [ACC_WIDTH:0]   rsum;
   logic signed [ACC_WIDTH:0]   rshift;
   logic signed [ACC_WIDTH:0]   r2;
   logic                        done2;
   logic [7:0]                  clamped;

   // Stage 1 datapath: chunk 0 starts from the bias, later chunks from the running sum.
   always_comb begin
      data_ext   = {{(ACC_WIDTH - IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
      first_beat = (cnt == '0);
      last_beat  = (cnt == LAST_CNT);
      add_a      = first_beat ? i_bias : acc;
      add_sum    = add_a + data_ext;
      add_ovf    = (add_a[ACC_WIDTH-1] == data_ext[ACC_WIDTH-1]) &&
                   (add_sum[ACC_WIDTH-1] != add_a[ACC_WIDTH-1]);
   end

   // Stage 2 datapath: one extra bit of headroom keeps the rounding add exact.
   always_comb begin
      rnd = '0;
      if (shift1 != 5'd0) rnd = (ACC_WIDTH + 1)'(1) << (shift1 - 5'd1);
      rsum   = {acc[ACC_WIDTH-1], acc} + rnd;
      rshift = rsum >>> shift1;
   end

   // Stage 3 datapath: negative results clamp to 0, which doubles as ReLU.
   always_comb begin
      clamped = r2[7:0];
      if (r2[ACC_WIDTH])            clamped = 8'd0;
      else if (|r2[ACC_WIDTH-1:8])  clamped = 8'd255;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc    <= '0;
         o_ovf  <= 1'b0;
         done1  <= 1'b0;
         shift1 <= '0;
      end else if (i_clear) begin
         cnt    <= '0;
         acc    <= '0;
         o_ovf  <= 1'b0;
         done1  <= 1'b0;
         shift1 <= '0;
      end else begin
         done1 <= 1'b0;
         if (i_valid) begin
            acc <= add_sum;
            if (add_ovf) o_ovf <= 1'b1;
            if (last_beat) begin
               cnt    <= '0;
               shift1 <= i_shift;
               done1  <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done2   <= 1'b0;
         r2      <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_clear) begin
         done2   <= 1'b0;
         r2      <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         done2   <= done1;
         o_valid <= done2;
         if (done1) r2 <= rshift;
         if (done2) o_data <= clamped;
      end
   end

   assign o_busy = (cnt != '0);

endmodule

// File: tb/tb_macc_psum_requant.sv
// Directed bench for macc_psum_requant: accumulation, rounding/clamp, bias sampling,
// back-to-back neurons, gaps, clear, overflow and mid-neuron reset.
module tb_macc_psum_requant;

   logic               clk;
   logic               rst_n;
   logic signed [21:0] i_data;
   logic               i_valid;
   logic signed [31:0] i_bias;
   logic [4:0]         i_shift;
   logic               i_clear;
   logic [7:0]         o_data;
   logic               o_valid;
   logic               o_busy;
   logic               o_ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = 0;
   int t_a, t_b;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         got_cyc_q[$];

   macc_psum_requant dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_bias  (i_bias),
      .i_shift (i_shift),
      .i_clear (i_clear),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_busy  (o_busy),
      .o_ovf   (o_ovf)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor
   always @(negedge clk) begin
      if (o_valid) begin
         got_q.push_back(o_data);
         got_cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int d, input int b, input int s);
      i_data  = 22'(d);
      i_bias  = 32'(b);
      i_shift = 5'(s);
      i_valid = 1'b1;
      @(negedge clk);
      i_valid  = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic neuron(input int d0, input int d1, input int d2, input int d3,
                         input int b, input int s);
      send(d0, b, s);
      send(d1, b, s);
      send(d2, b, s);
      send(d3, b, s);
   endtask

   task automatic expect_neuron(input string tag, input int exp, input int exp_cyc);
      logic [7:0] e;
      exp_q.push_back(8'(exp));
      for (int i = 0; i < 12 && got_q.size() == 0; i++) @(negedge clk);
      chk({tag, "_arrive"}, int'(got_q.size() > 0), 1);
      e = exp_q.pop_front();
      if (got_q.size() > 0) begin
         chk({tag, "_data"}, int'(got_q.pop_front()), int'(e));
         chk({tag, "_lat"}, got_cyc_q.pop_front(), exp_cyc);
      end
   endtask

   task automatic drain_check(input string tag);
      idle(5);
      chk({tag, "_extra_out"}, got_q.size(), 0);
      got_q.delete();
      got_cyc_q.delete();
   endtask

   task automatic do_clear(input logic with_valid);
      i_clear = 1'b1;
      i_valid = with_valid;
      i_data  = 22'(99999);
      @(negedge clk);
      i_clear = 1'b0;
      i_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_bias = '0; i_shift = '0; i_clear = 1'b0;
      idle(2);
      chk("rst_data", o_data, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ovf", o_ovf, 0);
      rst_n = 1'b1;
      idle(1);

      // basic with busy tracking
      send(100, 0, 8);  chk("basic_busy1", o_busy, 1);
      send(200, 0, 8);  chk("basic_busy2", o_busy, 1);
      send(300, 0, 8);  chk("basic_busy3", o_busy, 1);
      send(424, 0, 8);  chk("basic_busy4", o_busy, 0);
      t_a = last_cyc;
      expect_neuron("basic", 4, t_a + 2);
      chk("basic_hold", o_data, 4);
      drain_check("basic");

      // rounding and clamp
      neuron(383, 0, 0, 0, 0, 8);     expect_neuron("rnd383", 1, last_cyc + 2);
      neuron(384, 0, 0, 0, 0, 8);     expect_neuron("rnd384", 2, last_cyc + 2);
      neuron(-5000, 0, 0, 0, 0, 8);   expect_neuron("neg", 0, last_cyc + 2);
      neuron(100000, 0, 0, 0, 0, 8);  expect_neuron("sat", 255, last_cyc + 2);
      neuron(3, 4, 0, 0, 0, 0);       expect_neuron("shift0", 7, last_cyc + 2);
      neuron(-100, 0, 0, 0, 0, 0);    expect_neuron("neg_shift0", 0, last_cyc + 2);
      drain_check("round");

      // bias sampled only on chunk 0
      neuron(512, 0, 0, 0, -256, 8);  expect_neuron("bias", 1, last_cyc + 2);
      send(1024, 0, 8); send(0, 5000, 8); send(0, 5000, 8); send(0, 5000, 8);
      expect_neuron("bias_late", 4, last_cyc + 2);
      drain_check("bias");

      // back-to-back neurons
      neuron(256, 256, 256, 256, 0, 8);
      t_a = last_cyc;
      neuron(512, 512, 512, 512, 0, 8);
      t_b = last_cyc;
      expect_neuron("b2b_first", 4, t_a + 2);
      expect_neuron("b2b_second", 8, t_b + 2);
      drain_check("b2b");

      // gaps between chunks
      send(100, 0, 8); idle(3);
      send(200, 0, 8); idle(1);
      send(300, 0, 8); idle(2);
      send(424, 0, 8);
      expect_neuron("gaps", 4, last_cyc + 2);
      drain_check("gaps");

      // clear mid-neuron, with a dropped beat in the clear cycle
      send(1000, 0, 8); send(1000, 0, 8);
      do_clear(1'b1);
      chk("clr_busy", o_busy, 0);
      neuron(512, 512, 512, 512, 0, 8);
      expect_neuron("clr_fresh", 8, last_cyc + 2);
      drain_check("clr_mid");

      // clear one cycle after a last beat kills that output
      neuron(256, 256, 256, 256, 0, 8);
      do_clear(1'b0);
      drain_check("clr_inflight");
      chk("clr_inflight_data", o_data, 0);

      // sticky overflow
      send(256, 32'h7FFF_FFF0, 8);
      chk("ovf_set", o_ovf, 1);
      send(0, 0, 8); send(0, 0, 8); send(0, 0, 8);
      expect_neuron("ovf_out", 0, last_cyc + 2);
      neuron(1024, 0, 0, 0, 0, 8);
      expect_neuron("ovf_next", 4, last_cyc + 2);
      chk("ovf_sticky", o_ovf, 1);
      do_clear(1'b0);
      chk("ovf_cleared", o_ovf, 0);
      drain_check("ovf");

      // reset mid-neuron
      send(700, 0, 8); send(700, 0, 8);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_busy", o_busy, 0);
      chk("mrst_data", o_data, 0);
      chk("mrst_valid", o_valid, 0);
      chk("mrst_ovf", o_ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      neuron(1024, 0, 0, 0, 0, 8);
      expect_neuron("mrst_next", 4, last_cyc + 2);
      drain_check("mrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=%0d expected=%0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
